// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operation/result handshake bundle for the EX-stage ALU
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic             busy;
    modport master (
        output in_valid, aluop, funct, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err, busy
    );
    modport slave (
        input  in_valid, aluop, funct, a, b, out_ready,
        output in_ready, out_valid, result, zero, err, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS EX-stage ALU decode+execute with registered, handshaked result; define ALU_EXEC_MDU_EN to build iterative MULT/DIVU
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input logic            clk,
    input logic            reset_n,
    alu_exec_unit_if.slave bus
);
    logic [WIDTH-1:0] w_res, w_fin, r_result;
    logic [31:0]      w_add32, w_sub32;
    logic             w_err, w_mul, w_div, w_take, w_done, w_idle, w_slt;
    logic             r_valid, r_zero, r_err;
    assign w_add32 = bus.a[31:0] + bus.b[31:0];
    assign w_sub32 = bus.a[31:0] - bus.b[31:0];
    assign w_slt   = $signed(bus.a) < $signed(bus.b);
    // Decode aluop/funct into the single-cycle result, error flag and iterative-op requests
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        w_mul = 1'b0;
        w_div = 1'b0;
        case (bus.aluop)
            3'b000: w_res = {{(WIDTH-32){w_add32[31]}}, w_add32};
            3'b001: w_res = {{(WIDTH-32){w_sub32[31]}}, w_sub32};
            3'b011: w_res = bus.a & bus.b;
            3'b100: w_res = bus.a | bus.b;
            3'b101: w_res = WIDTH'(w_slt);
            3'b110: w_res = bus.a + bus.b;
            3'b010:
                case (bus.funct)
                    6'b100000: w_res = {{(WIDTH-32){w_add32[31]}}, w_add32};
                    6'b100010: w_res = {{(WIDTH-32){w_sub32[31]}}, w_sub32};
                    6'b100100: w_res = bus.a & bus.b;
                    6'b100101: w_res = bus.a | bus.b;
                    6'b101010: w_res = WIDTH'(w_slt);
                    6'b101100: w_res = bus.a + bus.b;
                    6'b101110: w_res = bus.a - bus.b;
`ifdef ALU_EXEC_MDU_EN
                    6'b011000: w_mul = 1'b1;
                    6'b011011: w_div = 1'b1;
`endif
                    default:   w_err = 1'b1;
                endcase
            default: w_err = 1'b1;
        endcase
    end
    assign w_take       = bus.in_valid && bus.in_ready;
    assign bus.in_ready = w_idle && (!r_valid || bus.out_ready);
`ifdef ALU_EXEC_MDU_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc, r_opa, r_opb, w_acc_nxt, w_opa_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    assign w_idle   = r_state == IDLE;
    assign w_done   = !w_idle && r_cnt == CNT_W'(1);
    assign bus.busy = !w_idle;
    assign w_rem_sh = {r_acc, r_opa[WIDTH-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_opb};
    assign w_fin    = r_state == MUL ? w_acc_nxt : w_opa_nxt;
    // One iteration: shift-add (multiplier LSB first) or restoring divide step (quotient MSB first)
    always_comb begin
        w_acc_nxt = r_acc;
        w_opa_nxt = r_opa;
        if (r_state == MUL) begin
            w_acc_nxt = r_acc + (r_opa[0] ? r_opb : '0);
            w_opa_nxt = r_opa >> 1;
        end else if (r_state == DIV) begin
            w_acc_nxt = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_opb}) : w_rem_sh[WIDTH-1:0];
            w_opa_nxt = {r_opa[WIDTH-2:0], w_ge};
        end
    end
    // Next state: leave IDLE on an iterative transfer, return when the counter expires
    always_comb begin
        w_state_nxt = r_state;
        if (w_take && w_mul) w_state_nxt = MUL;
        else if (w_take && w_div) w_state_nxt = DIV;
        else if (w_done) w_state_nxt = IDLE;
    end
    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    // Iteration registers: latch operands on transfer, step once per cycle while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_opa <= '0;
            r_opb <= '0;
        end else if (w_take && (w_mul || w_div)) begin
            r_cnt <= CNT_W'(WIDTH);
            r_acc <= '0;
            r_opa <= bus.a;
            r_opb <= bus.b;
        end else if (!w_idle) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= w_acc_nxt;
            r_opa <= w_opa_nxt;
            r_opb <= r_state == MUL ? r_opb << 1 : r_opb;
        end
    end
`else
    assign w_idle   = 1'b1;
    assign w_done   = 1'b0;
    assign w_fin    = '0;
    assign bus.busy = 1'b0;
`endif
    // Result register: single-cycle ops load on transfer, iterative ops load on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_take && !(w_mul || w_div)) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_zero   <= w_res == '0;
            r_err    <= w_err;
        end else if (w_take) begin
            r_valid  <= 1'b0;
        end else if (w_done) begin
            r_valid  <= 1'b1;
            r_result <= w_fin;
            r_zero   <= w_fin == '0;
            r_err    <= 1'b0;
        end else if (bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end
    assign bus.out_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table, hand sequences and randomized model check for alu_exec_unit
module tb_alu_exec_unit;
    localparam int W = 64;
`ifdef ALU_EXEC_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    alu_exec_unit_if #(.WIDTH(W)) bus ();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         e;
        int           lat;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: classify the operation, then compute with plain arithmetic
    function automatic void model(input logic [2:0] op, input logic [5:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r, output logic e,
                                  output int lat);
        int k;
        logic [31:0] s;
        k = -1;
        case (op)
            3'b000: k = 0;
            3'b001: k = 1;
            3'b011: k = 2;
            3'b100: k = 3;
            3'b101: k = 4;
            3'b110: k = 5;
            3'b010:
                case (f)
                    6'h20: k = 0;
                    6'h22: k = 1;
                    6'h24: k = 2;
                    6'h25: k = 3;
                    6'h2a: k = 4;
                    6'h2c: k = 5;
                    6'h2e: k = 6;
                    6'h18: k = MDU ? 7 : -1;
                    6'h1b: k = MDU ? 8 : -1;
                    default: k = -1;
                endcase
            default: k = -1;
        endcase
        e = k < 0;
        lat = k >= 7 ? W : 0;
        r = '0;
        case (k)
            0: begin s = a[31:0] + b[31:0]; r = {{32{s[31]}}, s}; end
            1: begin s = a[31:0] - b[31:0]; r = {{32{s[31]}}, s}; end
            2: r = a & b;
            3: r = a | b;
            4: r = $signed(a) < $signed(b) ? 64'd1 : 64'd0;
            5: r = a + b;
            6: r = a - b;
            7: r = a * b;
            8: r = b == '0 ? '1 : a / b;
            default: r = '0;
        endcase
    endfunction

    // Present one op, wait for its result, check it and the latency, then consume it
    task automatic run_op(input string name, input logic [2:0] op, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] er,
                          input logic ee, input int elat);
        int n;
        bit bad;
        bus.aluop = op;
        bus.funct = f;
        bus.a = a;
        bus.b = b;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_rdy"}, W'(bus.in_ready), W'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        bad = 1'b0;
        while (!bus.out_valid && n < W + 20) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1; n++;
        end
        check({name, "_lat"}, W'(n), W'(elat));
        check({name, "_res"}, bus.result, er);
        check({name, "_err"}, W'(bus.err), W'(ee));
        check({name, "_zero"}, W'(bus.zero), W'(er == '0));
        if (elat > 0) check({name, "_busy"}, W'(bad), W'(0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_drop"}, W'(bus.out_valid), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rr;
        logic [2:0]   rop;
        logic [5:0]   rf;
        logic         re;
        int           rl, n;
        bit           bad;
        logic [2:0]   ops[14]  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
                                   3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        logic [5:0]   fs[14]   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h20, 6'h2a, 6'h2e, 6'h18, 6'h1b, 6'h03, 6'h2c};
        vecs[0]  = '{"add_ovf", 3'b010, 6'h20, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 0};
        vecs[1]  = '{"dadd", 3'b110, 6'h00, 64'h7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000, 1'b0, 0};
        vecs[2]  = '{"dsub_eq", 3'b010, 6'h2e, 64'd5, 64'd5, 64'd0, 1'b0, 0};
        vecs[3]  = '{"sub_wrap", 3'b001, 6'h00, 64'd0, 64'd1, '1, 1'b0, 0};
        vecs[4]  = '{"and", 3'b011, 6'h00, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 0};
        vecs[5]  = '{"or", 3'b100, 6'h00, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 0};
        vecs[6]  = '{"slt_neg", 3'b101, 6'h00, '1, 64'd1, 64'd1, 1'b0, 0};
        vecs[7]  = '{"slt_pos", 3'b010, 6'h2a, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 0};
        vecs[8]  = '{"ill_op", 3'b111, 6'h00, 64'd3, 64'd4, 64'd0, 1'b1, 0};
        vecs[9]  = '{"ill_fn", 3'b010, 6'h00, 64'd3, 64'd4, 64'd0, 1'b1, 0};
        vecs[10] = MDU ? '{"mult", 3'b010, 6'h18, 64'h1_0000_0003, 64'd7, 64'h7_0000_0015, 1'b0, W}
                       : '{"mult", 3'b010, 6'h18, 64'h1_0000_0003, 64'd7, 64'd0, 1'b1, 0};
        vecs[11] = MDU ? '{"divu", 3'b010, 6'h1b, 64'd100, 64'd7, 64'd14, 1'b0, W}
                       : '{"divu", 3'b010, 6'h1b, 64'd100, 64'd7, 64'd0, 1'b1, 0};
        vecs[12] = MDU ? '{"divu0", 3'b010, 6'h1b, 64'd9, 64'd0, '1, 1'b0, W}
                       : '{"divu0", 3'b010, 6'h1b, 64'd9, 64'd0, 64'd0, 1'b1, 0};
        vecs[13] = '{"add_hi", 3'b000, 6'h00, 64'hABCD_0000_0000_0001, 64'h1234_0000_0000_0002, 64'd3, 1'b0, 0};
        vecs[14] = '{"dsub_wrap", 3'b010, 6'h2e, 64'd0, 64'd1, '1, 1'b0, 0};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.aluop = '0;
        bus.funct = '0;
        bus.a = '0;
        bus.b = '0;
        #1;
        check("rst_valid", W'(bus.out_valid), W'(0));
        check("rst_result", bus.result, '0);
        check("rst_zero", W'(bus.zero), W'(0));
        check("rst_err", W'(bus.err), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_ready", W'(bus.in_ready), W'(1));
        #20;
        @(posedge clk); #1;
        reset_n = 1'b1;
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].lat);
        // back-to-back single-cycle ops with the consumer always ready
        bus.aluop = 3'b110; bus.funct = 6'h00; bus.a = 64'h7FFF_FFFF; bus.b = 64'd1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        check("b2b_rdy0", W'(bus.in_ready), W'(1));
        @(posedge clk); #1;
        check("b2b_res0", bus.result, 64'h8000_0000);
        check("b2b_rdy1", W'(bus.in_ready), W'(1));
        bus.aluop = 3'b010; bus.funct = 6'h2e; bus.a = 64'd5; bus.b = 64'd5;
        @(posedge clk); #1;
        check("b2b_res1", bus.result, 64'd0);
        check("b2b_zero1", W'(bus.zero), W'(1));
        check("b2b_valid1", W'(bus.out_valid), W'(1));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drop", W'(bus.out_valid), W'(0));
        // backpressure: result held and no new op accepted while the consumer stalls
        bus.out_ready = 1'b0;
        bus.aluop = 3'b011; bus.funct = 6'h00; bus.a = 64'hFF; bus.b = 64'h3C;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.aluop = 3'b100; bus.a = 64'h1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", W'(bus.in_ready), W'(0));
            check("bp_result", bus.result, 64'h3C);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_drop", W'(bus.out_valid), W'(0));
        // reset in the middle of a divide abandons it
        bus.aluop = 3'b010; bus.funct = 6'h1b; bus.a = 64'd1000; bus.b = 64'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", W'(bus.busy), W'(MDU));
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", W'(bus.out_valid), W'(0));
        check("mid_rst_busy", W'(bus.busy), W'(0));
        check("mid_rst_result", bus.result, '0);
        check("mid_rst_ready", W'(bus.in_ready), W'(1));
        @(posedge clk); #1;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("mid_no_result", W'(bad), W'(0));
        // randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 13));
            rop = ops[n];
            rf = fs[n];
            ra = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 50)) : {$urandom, $urandom};
            rb = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 9)) : {$urandom, $urandom};
            model(rop, rf, ra, rb, rr, re, rl);
            run_op($sformatf("rnd%0d", i), rop, rf, ra, rb, rr, re, rl);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
